// File: rtl/mem_dp_pipe.sv
// -----------------------------------------------------------------------------
// mem_dp_pipe
//   Simple dual-port memory (one write port, one read port) for the LSTM
//   datapath. Holds weight/state vectors between the matrix unit and the
//   gate/activation stages. Configurable read latency with a valid strobe,
//   and a clear engine that zeroes the array after reset or on request.
//
// Parameters
//   DWIDTH  data word width
//   DEPTH   number of words (>= 2, any value)
//   AWIDTH  address width, derived from DEPTH (leave at default)
//   RD_LAT  read latency in cycles (>= 1)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high; restarts the clear sweep
//   clear    pulse: zero the whole array
//   busy     high while the clear engine runs
//   wr_en    write strobe
//   wr_addr  write address (out-of-range writes are dropped)
//   wr_data  write data
//   rd_en    read request
//   rd_addr  read address (out-of-range reads return zero)
//   rd_data  read data, valid when rd_valid is high; holds otherwise
//   rd_valid read strobe, RD_LAT cycles after the accepted rd_en
//
// Build option
//   MEM_DP_BYPASS_EN  defined: a same-cycle read and write of the same
//                     in-range address returns the new write data.
//                     undefined: the read returns the old contents.
// -----------------------------------------------------------------------------
module mem_dp_pipe #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 512,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] clr_addr, clr_nxt;

  logic              port_ok;
  logic              wr_in_range, rd_in_range;
  logic              wr_hit, rd_acc, clr_we;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [DWIDTH-1:0] ram_q;
  logic              oob_q;
  logic              vld1;
  logic [DWIDTH-1:0] s1;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_addr;
    case (state)
      CLEAR: begin
        if (clear) begin
          clr_nxt = '0;
        end else if (clr_addr == LAST_ADDR) begin
          state_nxt = IDLE;
          clr_nxt   = '0;
        end else begin
          clr_nxt = clr_addr + 1'b1;
        end
      end
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
          clr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        clr_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);

  // ---------------------------------------------------------------------------
  // Port qualification: user ports only act in IDLE and never in a cycle where
  // clear or rst is sampled.
  // ---------------------------------------------------------------------------
  assign port_ok     = (state == IDLE) && !clear && !rst;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_hit      = port_ok && wr_en && wr_in_range;
  assign rd_acc      = port_ok && rd_en;
  assign clr_we      = (state == CLEAR) && !rst;

  // ---------------------------------------------------------------------------
  // Array: single write port shared by the clear sweep and the user write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_hit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read (read-first with respect to a same-cycle write).
  always_ff @(posedge clk) begin
    if (rd_acc && rd_in_range) begin
      ram_q <= mem[rd_addr];
    end
  end

  // First-stage control. oob_q is forced high on reset so the first stage
  // presents zero without needing a reset on the RAM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1  <= 1'b0;
      oob_q <= 1'b1;
    end else begin
      vld1 <= rd_acc;
      if (rd_acc) begin
        oob_q <= !rd_in_range;
      end
    end
  end

`ifdef MEM_DP_BYPASS_EN
  logic              fwd_q;
  logic [DWIDTH-1:0] wdat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q  <= 1'b0;
      wdat_q <= '0;
    end else if (rd_acc) begin
      fwd_q  <= wr_hit && rd_in_range && (wr_addr == rd_addr);
      wdat_q <= wr_data;
    end
  end

  always_comb begin
    s1 = ram_q;
    if (fwd_q) begin
      s1 = wdat_q;
    end
    if (oob_q) begin
      s1 = '0;
    end
  end
`else
  always_comb begin
    s1 = ram_q;
    if (oob_q) begin
      s1 = '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output stages: RD_LAT-1 registers after the RAM read. Each stage only
  // loads on a valid beat, so rd_data holds its last valid value.
  // ---------------------------------------------------------------------------
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rd_data  = s1;
      assign rd_valid = vld1;
    end else begin : g_latn
      logic [DWIDTH-1:0] pd [RD_LAT-1];
      logic [RD_LAT-2:0] pv;

      always_ff @(posedge clk) begin
        if (rst) begin
          pv <= '0;
          for (int unsigned k = 0; k < RD_LAT - 1; k++) begin
            pd[k] <= '0;
          end
        end else begin
          pv[0] <= vld1;
          if (vld1) begin
            pd[0] <= s1;
          end
          for (int unsigned k = 1; k < RD_LAT - 1; k++) begin
            pv[k] <= pv[k-1];
            if (pv[k-1]) begin
              pd[k] <= pd[k-1];
            end
          end
        end
      end

      assign rd_data  = pd[RD_LAT-2];
      assign rd_valid = pv[RD_LAT-2];
    end
  endgenerate

endmodule
